fifo_rr_sched: RTL and testbench
================================

// Module: fifo_rr_sched
// PURPOSE
//  Packet-level round-robin scheduler draining PORT_NUM show-ahead (FWFT) input FIFOs
//  into one shared output stream with a valid/ready handshake.
//  Grant is locked per packet (head word to eop); next grant searches circularly from last_grant+1.
//  out_port uses the 8'd128+idx / 8'd0 selection encoding consumed by downstream mux logic.
//  Sits between the per-port ingress FIFOs and the shared egress datapath.
// PARAMETERS
//  PORT_NUM       4    number of input FIFOs, 1..127
//  DW             32   data word width
//  MAX_PKT_WORDS  256  max words per packet before forced truncation, 2..65535
// PORTS
//  glb_clk        in   1             clock
//  glb_areset_n   in   1             reset, asynchronous, active-low
//  port_en        in   PORT_NUM      per-port arbitration enable; a 0 masks the port's request
//  fifo_nempty    in   PORT_NUM      FIFO i non-empty, head word valid
//  fifo_rd_data   in   PORT_NUM*DW   head word of FIFO i at [i*DW +: DW]
//  fifo_eop       in   PORT_NUM      head word of FIFO i is end-of-packet
//  fifo_rd_en     out  PORT_NUM      pop strobe, one-hot or zero, combinational
//  out_valid      out  1             output word valid
//  out_ready      in   1             downstream accepts the word when out_valid&&out_ready
//  out_data       out  DW            output word
//  out_sop        out  1             first word of packet
//  out_eop        out  1             last word of packet (real or forced)
//  out_port       out  8             8'd128+source idx while out_valid, else 8'd0
//  err_trunc      out  1             1-cycle pulse when a packet is truncated
// BEHAVIOUR
//  Reset: state=IDLE, last_grant=PORT_NUM-1, word_cnt=0.
//    All outputs 0; fifo_rd_en=0.
//    Reset takes effect immediately, including mid-packet. The FIFO head after reset is treated as sop.
//  Output register loads when load = !out_valid || out_ready.
//    If load is high and no pop occurs, out_valid clears on the next edge.
//  req = fifo_nempty & port_en.
//  IDLE:
//    - req==0: stay in IDLE.
//    - req!=0: grant = first set bit of req searching from last_grant+1, wrapping at PORT_NUM.
//    - On the grant edge: register grant, set last_grant=grant, word_cnt=0, go to XFER.
//    - No pop occurs in IDLE.
//  XFER:
//    - pop = load && fifo_nempty[grant]; fifo_rd_en[grant]=pop.
//    - On a pop edge, the output register gets data = head, sop = (word_cnt==0), port = 128+grant.
//    - On that same edge word_cnt increments.
//    - out_eop = fifo_eop[grant] || (word_cnt==MAX_PKT_WORDS-1).
//    - If the popped word has out_eop: go to IDLE.
//      If the eop was forced (not fifo_eop), also pulse err_trunc; the FIFO remainder is a new packet.
//    - Granted FIFO empty mid-packet: hold grant, no pop, no re-arbitration. out_valid drains to 0.
//    - port_en deassert mid-packet: ignored until the packet ends.
//  Latency: request seen in IDLE at cycle 0 -> grant at cycle 1 -> out_valid at cycle 2.
//  Throughput: 1 word/cycle within a packet when out_ready=1. One IDLE bubble between packets.
//  Backpressure: out_ready=0 with out_valid=1 holds out_* stable and fifo_rd_en=0.
//  Single-port case (only one req): the same port is regranted each packet.
// TESTING
//  1. Ports 0..3 each hold one 3-word packet, out_ready=1
//     -> order 0,1,2,3, out_port 128..131, 4 cycles/packet, sop/eop on words 1/3.
//  2. Port 2 holds 2 packets, port 0 holds 1, last_grant=1 -> order 2,0,2.
//  3. out_ready toggles 1010 during a 4-word packet
//     -> no word lost or duplicated; out_* stable while stalled; 4 pops total.
//  4. Port 1 FIFO empties after word 2 of 5, refills 6 cycles later
//     -> grant held, port 3 (requesting) not served until port 1's eop.
//  5. MAX_PKT_WORDS=4, 6-word packet -> word 4 has out_eop=1 and err_trunc pulses;
//     words 5-6 are emitted as a new packet with sop.
//  6. Assert glb_areset_n low mid-XFER -> all outputs 0 at once;
//     after release, first grant goes to the lowest requesting port, starting search at 0.

Source files
------------

// File: rtl/fifo_rr_sched_if.sv
// Bundle between the per-port ingress FIFOs, the round-robin scheduler and the egress stream.
// The master modport is the scheduler's view; the slave modport is the FIFO/egress side.
interface fifo_rr_sched_if #(
   parameter int PORT_NUM = 4,
   parameter int DW       = 32
);
   logic [PORT_NUM-1:0]    port_en;
   logic [PORT_NUM-1:0]    fifo_nempty;
   logic [PORT_NUM*DW-1:0] fifo_rd_data;
   logic [PORT_NUM-1:0]    fifo_eop;
   logic [PORT_NUM-1:0]    fifo_rd_en;
   logic                   out_valid;
   logic                   out_ready;
   logic [DW-1:0]          out_data;
   logic                   out_sop;
   logic                   out_eop;
   logic [7:0]             out_port;
   logic                   err_trunc;

   modport master (
      input  port_en, fifo_nempty, fifo_rd_data, fifo_eop, out_ready,
      output fifo_rd_en, out_valid, out_data, out_sop, out_eop, out_port, err_trunc
   );

   modport slave (
      output port_en, fifo_nempty, fifo_rd_data, fifo_eop, out_ready,
      input  fifo_rd_en, out_valid, out_data, out_sop, out_eop, out_port, err_trunc
   );
endinterface

// File: rtl/fifo_rr_sched.sv
// Packet-locked round-robin scheduler: drains PORT_NUM show-ahead FIFOs into one
// registered valid/ready stream, truncating packets longer than MAX_PKT_WORDS.
module fifo_rr_sched #(
   parameter int PORT_NUM      = 4,
   parameter int DW            = 32,
   parameter int MAX_PKT_WORDS = 256
) (
   input  logic           glb_clk,
   input  logic           glb_areset_n,
   fifo_rr_sched_if.master bus
);
   localparam int GW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
   localparam int CW = $clog2(MAX_PKT_WORDS);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_XFER = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [GW-1:0] grant_q, grant_d;
   logic [GW-1:0] last_grant_q, last_grant_d;
   logic [CW-1:0] word_cnt_q, word_cnt_d;
   logic          out_valid_q, out_valid_d;
   logic [DW-1:0] out_data_q, out_data_d;
   logic          out_sop_q, out_sop_d;
   logic          out_eop_q, out_eop_d;
   logic [7:0]    out_port_q, out_port_d;
   logic          err_trunc_q, err_trunc_d;

   logic [PORT_NUM-1:0] req;
   logic                load;
   logic                pop;
   logic                word_eop;
   logic                rr_found;
   logic                hi_found;
   logic [GW-1:0]       rr_idx;
   logic [GW-1:0]       hi_idx;
   logic [GW-1:0]       lo_idx;
   logic [DW-1:0]       head_data;
   logic                head_nempty;
   logic                head_eop;

   assign req  = bus.fifo_nempty & bus.port_en;
   assign load = !out_valid_q || bus.out_ready;

   // Lowest requester above last_grant wins; otherwise wrap to the lowest requester overall.
   always_comb begin
      hi_found = 1'b0;
      hi_idx   = '0;
      rr_found = 1'b0;
      lo_idx   = '0;
      for (int i = PORT_NUM - 1; i >= 0; i--) begin
         if (req[i]) begin
            rr_found = 1'b1;
            lo_idx   = GW'(i);
            if (GW'(i) > last_grant_q) begin
               hi_found = 1'b1;
               hi_idx   = GW'(i);
            end
         end
      end
      rr_idx = hi_found ? hi_idx : lo_idx;
   end

   always_comb begin
      head_data   = '0;
      head_nempty = 1'b0;
      head_eop    = 1'b0;
      for (int i = 0; i < PORT_NUM; i++) begin
         if (grant_q == GW'(i)) begin
            head_data   = bus.fifo_rd_data[i*DW +: DW];
            head_nempty = bus.fifo_nempty[i];
            head_eop    = bus.fifo_eop[i];
         end
      end
   end

   assign pop      = (state_q == ST_XFER) && load && head_nempty;
   assign word_eop = head_eop || (word_cnt_q == CW'(MAX_PKT_WORDS - 1));

   always_comb begin
      bus.fifo_rd_en = '0;
      for (int i = 0; i < PORT_NUM; i++) begin
         bus.fifo_rd_en[i] = pop && (grant_q == GW'(i));
      end
   end

   always_comb begin
      // NOTE: every _d gets a default before any branch so no path leaves it unassigned (no latch).
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      word_cnt_d   = word_cnt_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_sop_d    = out_sop_q;
      out_eop_d    = out_eop_q;
      out_port_d   = out_port_q;
      err_trunc_d  = 1'b0;

      if (load) begin
         out_valid_d = pop;
         out_sop_d   = pop && (word_cnt_q == '0);
         out_eop_d   = pop && word_eop;
         out_port_d  = pop ? (8'd128 | 8'(grant_q)) : 8'd0;
         if (pop) out_data_d = head_data;
      end

      case (state_q)
         ST_IDLE: begin
            if (rr_found) begin
               grant_d      = rr_idx;
               last_grant_d = rr_idx;
               word_cnt_d   = '0;
               state_d      = ST_XFER;
            end
         end
         ST_XFER: begin
            if (pop) begin
               word_cnt_d = word_cnt_q + 1'b1;
               if (word_eop) begin
                  state_d     = ST_IDLE;
                  err_trunc_d = !head_eop;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge glb_clk or negedge glb_areset_n) begin
      if (!glb_areset_n) begin
         state_q      <= ST_IDLE;
         grant_q      <= '0;
         last_grant_q <= GW'(PORT_NUM - 1);
         word_cnt_q   <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_sop_q    <= 1'b0;
         out_eop_q    <= 1'b0;
         out_port_q   <= 8'd0;
         err_trunc_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         word_cnt_q   <= word_cnt_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_sop_q    <= out_sop_d;
         out_eop_q    <= out_eop_d;
         out_port_q   <= out_port_d;
         err_trunc_q  <= err_trunc_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_sop   = out_sop_q;
   assign bus.out_eop   = out_eop_q;
   assign bus.out_port  = out_port_q;
   assign bus.err_trunc = err_trunc_q;
endmodule

// File: tb/tb_fifo_rr_sched.sv
// Directed bench: queue-based FIFO models feed two scheduler instances (MAX_PKT_WORDS 256 and 4);
// accepted output words are logged and compared against hand-built expected streams.
module tb_fifo_rr_sched;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [3:0]   en_r;
   logic [3:0]   nempty_r;
   logic [3:0]   eop_r;
   logic [127:0] data_r;
   logic         ready_r;
   logic         sel_t;

   fifo_rr_sched_if #(.PORT_NUM(4), .DW(32)) bus ();
   fifo_rr_sched_if #(.PORT_NUM(4), .DW(32)) bus_t ();

   assign bus.port_en        = sel_t ? 4'b0 : en_r;
   assign bus.fifo_nempty    = nempty_r;
   assign bus.fifo_rd_data   = data_r;
   assign bus.fifo_eop       = eop_r;
   assign bus.out_ready      = ready_r;
   assign bus_t.port_en      = sel_t ? en_r : 4'b0;
   assign bus_t.fifo_nempty  = nempty_r;
   assign bus_t.fifo_rd_data = data_r;
   assign bus_t.fifo_eop     = eop_r;
   assign bus_t.out_ready    = ready_r;

   fifo_rr_sched #(.PORT_NUM(4), .DW(32), .MAX_PKT_WORDS(256)) u_dut (
      .glb_clk      (clk),
      .glb_areset_n (rst_n),
      .bus          (bus.master)
   );

   fifo_rr_sched #(.PORT_NUM(4), .DW(32), .MAX_PKT_WORDS(4)) u_dut_t (
      .glb_clk      (clk),
      .glb_areset_n (rst_n),
      .bus          (bus_t.master)
   );

   // Selected DUT view
   logic [3:0]  m_rd_en;
   logic        m_valid, m_sop, m_eop, m_trunc;
   logic [31:0] m_data;
   logic [7:0]  m_port;
   assign m_rd_en = sel_t ? bus_t.fifo_rd_en : bus.fifo_rd_en;
   assign m_valid = sel_t ? bus_t.out_valid  : bus.out_valid;
   assign m_sop   = sel_t ? bus_t.out_sop    : bus.out_sop;
   assign m_eop   = sel_t ? bus_t.out_eop    : bus.out_eop;
   assign m_trunc = sel_t ? bus_t.err_trunc  : bus.err_trunc;
   assign m_data  = sel_t ? bus_t.out_data   : bus.out_data;
   assign m_port  = sel_t ? bus_t.out_port   : bus.out_port;

   logic [3:0]  rd_seen;
   logic        acc_seen;
   logic [41:0] word_seen;
   always @(posedge clk) begin
      rd_seen   <= m_rd_en;
      acc_seen  <= m_valid && ready_r;
      word_seen <= {m_port, m_sop, m_eop, m_data};
   end

   logic [32:0] q0[$], q1[$], q2[$], q3[$];
   logic [41:0] log_q[$], exp_q[$];
   int          log_t[$];
   int          n_chk = 0, n_bad = 0, cyc_n = 0, n_pop = 0, trunc_n = 0;
   logic [31:0] trunc_word;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mkw(input int p, input int k, input int w);
      return {8'(p), 8'(k), 16'(w)};
   endfunction

   function automatic logic [41:0] ew(input int p, input int k, input int w, input bit s, input bit e);
      return {8'(128 + p), s, e, mkw(p, k, w)};
   endfunction

   task automatic refresh();
      nempty_r = {q3.size() != 0, q2.size() != 0, q1.size() != 0, q0.size() != 0};
      {eop_r[0], data_r[31:0]}   = (q0.size() != 0) ? q0[0] : 33'd0;
      {eop_r[1], data_r[63:32]}  = (q1.size() != 0) ? q1[0] : 33'd0;
      {eop_r[2], data_r[95:64]}  = (q2.size() != 0) ? q2[0] : 33'd0;
      {eop_r[3], data_r[127:96]} = (q3.size() != 0) ? q3[0] : 33'd0;
   endtask

   task automatic push_words(input int p, input int k, input int w0, input int n, input bit eop_last);
      for (int w = w0; w < w0 + n; w++) begin
         logic [32:0] e;
         e = {eop_last && (w == w0 + n - 1), mkw(p, k, w)};
         case (p)
            0: q0.push_back(e);
            1: q1.push_back(e);
            2: q2.push_back(e);
            default: q3.push_back(e);
         endcase
      end
      refresh();
   endtask

   task automatic push_pkt(input int p, input int k, input int n);
      push_words(p, k, 0, n, 1'b1);
   endtask

   task automatic exp_pkt(input int p, input int k, input int w0, input int n, input bit s0);
      for (int w = w0; w < w0 + n; w++) exp_q.push_back(ew(p, k, w, s0 && (w == w0), w == w0 + n - 1));
   endtask

   // One clock: apply pops seen at the edge, log accepted words, re-drive FIFO heads.
   task automatic cyc();
      @(negedge clk);
      cyc_n++;
      if (rd_seen[0] && q0.size() != 0) void'(q0.pop_front());
      if (rd_seen[1] && q1.size() != 0) void'(q1.pop_front());
      if (rd_seen[2] && q2.size() != 0) void'(q2.pop_front());
      if (rd_seen[3] && q3.size() != 0) void'(q3.pop_front());
      n_pop += $countones(rd_seen);
      if (acc_seen) begin
         log_q.push_back(word_seen);
         log_t.push_back(cyc_n);
      end
      if (m_trunc) begin
         trunc_n++;
         trunc_word = m_data;
      end
      refresh();
   endtask

   task automatic run(input int n);
      repeat (n) cyc();
   endtask

   task automatic clear_log();
      log_q.delete();
      log_t.delete();
      exp_q.delete();
   endtask

   task automatic cmp_log(input string tag);
      chk($sformatf("%s_len", tag), 64'(log_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
         chk($sformatf("%s[%0d]", tag, i), 64'(log_q[i]), 64'(exp_q[i]));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      run(2);
      rst_n = 1'b1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, 64'(m_valid), 64'd0);
      chk({tag, "_sop"},   64'(m_sop),   64'd0);
      chk({tag, "_eop"},   64'(m_eop),   64'd0);
      chk({tag, "_port"},  64'(m_port),  64'd0);
      chk({tag, "_data"},  64'(m_data),  64'd0);
      chk({tag, "_trunc"}, 64'(m_trunc), 64'd0);
      chk({tag, "_rd_en"}, 64'(m_rd_en), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [41:0] prev;
      logic        stall;
      int          p0;
      en_r    = 4'hF;
      ready_r = 1'b1;
      sel_t   = 1'b0;
      refresh();
      run(2);
      chk_zero("reset");
      rst_n = 1'b1;
      run(1);

      // 1: one 3-word packet per port, served 0..3, 4 cycles per packet
      clear_log();
      for (int p = 0; p < 4; p++) push_pkt(p, 1, 3);
      cyc();
      chk("t1_lat_c1_valid", 64'(m_valid), 64'd0);
      cyc();
      chk("t1_lat_c2_valid", 64'(m_valid), 64'd1);
      chk("t1_lat_c2_port",  64'(m_port),  64'd128);
      chk("t1_lat_c2_sop",   64'(m_sop),   64'd1);
      run(20);
      for (int p = 0; p < 4; p++) exp_pkt(p, 1, 0, 3, 1'b1);
      cmp_log("t1");
      if (log_t.size() >= 10) begin
         chk("t1_pkt_spacing", 64'(log_t[3] - log_t[0]), 64'd4);
         chk("t1_pkt3_start",  64'(log_t[9] - log_t[0]), 64'd12);
      end

      // 2: force last_grant=1, then port 2 has two packets and port 0 one -> 2,0,2
      clear_log();
      push_pkt(1, 2, 2);
      run(8);
      push_pkt(2, 3, 2);
      push_pkt(2, 4, 2);
      push_pkt(0, 3, 2);
      run(20);
      exp_pkt(1, 2, 0, 2, 1'b1);
      exp_pkt(2, 3, 0, 2, 1'b1);
      exp_pkt(0, 3, 0, 2, 1'b1);
      exp_pkt(2, 4, 0, 2, 1'b1);
      cmp_log("t2");

      // 3: out_ready toggling during a 4-word packet
      clear_log();
      p0 = n_pop;
      push_pkt(0, 5, 4);
      for (int i = 0; i < 14; i++) begin
         ready_r = (i >= 8) || (i % 2 == 0);
         #1;
         stall = m_valid && !ready_r;
         if (stall) chk("t3_rd_en_stall", 64'(m_rd_en), 64'd0);
         prev = {m_port, m_sop, m_eop, m_data};
         cyc();
         if (stall) begin
            chk("t3_hold_valid", 64'(m_valid), 64'd1);
            chk("t3_hold_out", 64'({m_port, m_sop, m_eop, m_data}), 64'(prev));
         end
      end
      ready_r = 1'b1;
      run(4);
      exp_pkt(0, 5, 0, 4, 1'b1);
      cmp_log("t3");
      chk("t3_pops", 64'(n_pop - p0), 64'd4);

      // 4: port 1 runs dry mid-packet; port 3 must wait for port 1's eop
      do_reset();
      clear_log();
      push_words(1, 6, 0, 2, 1'b0);
      push_pkt(3, 6, 3);
      for (int i = 0; i < 20 && log_q.size() < 2; i++) cyc();
      chk("t4_first_words", 64'(log_q.size()), 64'd2);
      run(6);
      chk("t4_gap_valid", 64'(m_valid), 64'd0);
      chk("t4_port3_untouched", 64'(q3.size()), 64'd3);
      push_words(1, 6, 2, 3, 1'b1);
      run(20);
      exp_q.push_back(ew(1, 6, 0, 1'b1, 1'b0));
      exp_pkt(1, 6, 1, 4, 1'b0);
      exp_pkt(3, 6, 0, 3, 1'b1);
      cmp_log("t4");

      // 5: MAX_PKT_WORDS=4 instance, 6-word packet is cut after word 4
      sel_t = 1'b1;
      do_reset();
      clear_log();
      trunc_n = 0;
      push_pkt(2, 7, 6);
      run(16);
      exp_pkt(2, 7, 0, 4, 1'b1);
      exp_pkt(2, 7, 4, 2, 1'b1);
      cmp_log("t5");
      chk("t5_trunc_pulses", 64'(trunc_n), 64'd1);
      chk("t5_trunc_word", 64'(trunc_word), 64'(mkw(2, 7, 3)));
      sel_t = 1'b0;

      // 6: reset mid-XFER; search restarts from port 0
      do_reset();
      clear_log();
      push_pkt(1, 8, 2);
      run(8);
      push_pkt(2, 8, 5);
      for (int i = 0; i < 20 && log_q.size() < 4; i++) cyc();
      chk("t6_pre_words", 64'(log_q.size()), 64'd4);
      #2 rst_n = 1'b0;
      #1 chk_zero("t6_async");
      push_pkt(3, 9, 2);
      run(2);
      rst_n = 1'b1;
      run(16);
      exp_pkt(1, 8, 0, 2, 1'b1);
      exp_q.push_back(ew(2, 8, 0, 1'b1, 1'b0));
      exp_q.push_back(ew(2, 8, 1, 1'b0, 1'b0));
      exp_pkt(2, 8, 3, 2, 1'b1);
      exp_pkt(3, 9, 0, 2, 1'b1);
      cmp_log("t6");

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
